// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares one single-port, word-addressed instruction memory
// between the fetch stage (F, read-only) and the loader/debug port (L, read
// and write). The loader has fixed priority. A wait counter bounds how long
// fetch can be starved. Memory reads have one cycle of latency, so every
// response appears on its owner's port one cycle after the grant.
module imem_port_arbiter #(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  // fetch port
  input  logic          f_req,
  input  logic [31:0]   f_addr,
  output logic          f_gnt,
  output logic          f_rvalid,
  output logic [31:0]   f_rdata,
  output logic          f_err,
  // loader port
  input  logic          l_req,
  input  logic          l_we,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          l_err,
  // memory side
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
);

  localparam logic [29:0] LP_DEPTH    = 30'(DEPTH);
  localparam logic [3:0]  LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0]  r_wait_cnt;
  logic        r_f_rvalid;
  logic        r_f_err;
  logic [31:0] r_f_rdata;
  logic        r_l_rvalid;
  logic        r_l_err;
  logic [31:0] r_l_rdata;

  logic [29:0] w_f_idx;
  logic [29:0] w_l_idx;
  logic [29:0] w_sel_idx;
  logic        w_f_win;
  logic        w_f_gnt;
  logic        w_l_gnt;
  logic        w_sel_in_range;
  logic [31:0] w_f_rdata_now;
  logic [31:0] w_l_rdata_now;
  logic        w_unused;

  // Byte addresses become word indices; the two low bits carry no meaning.
  assign w_f_idx  = f_addr[31:2];
  assign w_l_idx  = l_addr[31:2];
  assign w_unused = ^{f_addr[1:0], l_addr[1:0]};

  // Fetch wins when it is alone, or when it has been starved long enough.
  assign w_f_win = f_req & (~l_req | (r_wait_cnt == LP_MAX_WAIT));

  // Grants are held low for the whole time reset is asserted, not only at edges.
  assign w_f_gnt = rst & w_f_win;
  assign w_l_gnt = rst & l_req & ~w_f_win;
  assign f_gnt   = w_f_gnt;
  assign l_gnt   = w_l_gnt;

  // The granted owner's address drives the memory. Out-of-range indices
  // produce no access, but mem_addr still shows the truncated index.
  assign w_sel_idx      = w_l_gnt ? w_l_idx : w_f_idx;
  assign w_sel_in_range = (w_sel_idx < LP_DEPTH);
  assign mem_en         = (w_f_gnt | w_l_gnt) & w_sel_in_range;
  assign mem_we         = w_l_gnt & l_we & w_sel_in_range;
  assign mem_addr       = rst ? w_sel_idx[AW-1:0] : '0;
  assign mem_wdata      = rst ? l_wdata : '0;

  // Starvation counter: counts consecutive refused fetch cycles, saturating.
  // NOTE: state updates use non-blocking assignments, so every always_ff sees
  // pre-edge values and the result does not depend on block evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (f_req && !w_f_gnt) begin
      if (r_wait_cnt != LP_MAX_WAIT) r_wait_cnt <= r_wait_cnt + 4'd1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Response flags: they record who owns the access that is still in flight,
  // and whether that access was out of range (read error or dropped write).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_rvalid <= 1'b0;
      r_f_err    <= 1'b0;
      r_l_rvalid <= 1'b0;
      r_l_err    <= 1'b0;
    end else begin
      r_f_rvalid <= w_f_gnt;
      r_f_err    <= w_f_gnt & ~w_sel_in_range;
      r_l_rvalid <= w_l_gnt & ~l_we;
      r_l_err    <= w_l_gnt & ~w_sel_in_range;
    end
  end

  // Read data for the in-flight response; out-of-range reads return zero.
  assign w_f_rdata_now = r_f_err ? 32'd0 : mem_rdata;
  assign w_l_rdata_now = r_l_err ? 32'd0 : mem_rdata;

  // Hold registers keep the last delivered word once rvalid drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_f_rdata <= '0;
      r_l_rdata <= '0;
    end else begin
      if (r_f_rvalid) r_f_rdata <= w_f_rdata_now;
      if (r_l_rvalid) r_l_rdata <= w_l_rdata_now;
    end
  end

  // NOTE: during the response cycle the memory output passes straight
  // through. Registering it again would add a second cycle of read latency.
  assign f_rdata  = r_f_rvalid ? w_f_rdata_now : r_f_rdata;
  assign l_rdata  = r_l_rvalid ? w_l_rdata_now : r_l_rdata;
  assign f_rvalid = r_f_rvalid;
  assign f_err    = r_f_err;
  assign l_rvalid = r_l_rvalid;
  assign l_err    = r_l_err;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: a behavioural memory sits behind the DUT,
// and a transaction-level reference model predicts grants and responses. A
// compare process checks every cycle, and directed literal checks pin the
// model to values worked out by hand.
module tb_imem_port_arbiter;

  localparam int DEPTH    = 1024;
  localparam int AW       = 10;
  localparam int MAX_WAIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          f_req, l_req, l_we;
  logic [31:0]   f_addr, l_addr, l_wdata;
  logic          f_gnt, f_rvalid, f_err, l_gnt, l_rvalid, l_err;
  logic [31:0]   f_rdata, l_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  imem_port_arbiter #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .f_err(f_err),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Behavioural single-port synchronous memory behind the arbiter.
  logic [31:0] mem_array [DEPTH];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_array[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          f_valid;
    bit          l_valid;
    bit          l_drop;
    bit          err;
    logic [31:0] data;
  } resp_t;

  logic [31:0] model_mem [DEPTH];
  int          denied;
  resp_t       exp_now;
  logic [31:0] hold_f, hold_l;

  function automatic bit in_range(input logic [31:0] a);
    return (a >> 2) < 32'(DEPTH);
  endfunction

  function automatic bit fetch_wins();
    return f_req && (!l_req || denied >= MAX_WAIT);
  endfunction

  always @(posedge clk or negedge rst) begin : model
    resp_t nxt;
    bit    fw;
    if (!rst) begin
      denied  = 0;
      exp_now = '{default: 0};
      hold_f  = 32'd0;
      hold_l  = 32'd0;
    end else begin
      if (exp_now.f_valid) hold_f = exp_now.data;
      if (exp_now.l_valid) hold_l = exp_now.data;
      nxt = '{default: 0};
      fw  = fetch_wins();
      if (fw) begin
        nxt.f_valid = 1'b1;
        nxt.err     = !in_range(f_addr);
        nxt.data    = nxt.err ? 32'd0 : model_mem[f_addr[11:2]];
      end else if (l_req) begin
        if (l_we) begin
          if (in_range(l_addr)) model_mem[l_addr[11:2]] = l_wdata;
          else begin
            nxt.l_drop = 1'b1;
            nxt.err    = 1'b1;
          end
        end else begin
          nxt.l_valid = 1'b1;
          nxt.err     = !in_range(l_addr);
          nxt.data    = nxt.err ? 32'd0 : model_mem[l_addr[11:2]];
        end
      end
      if (f_req && !fw) denied = (denied < MAX_WAIT) ? denied + 1 : denied;
      else              denied = 0;
      exp_now = nxt;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin : compare
    bit          fw, lw, inr;
    logic [31:0] sel;
    if (!rst) begin
      check("rst_f_gnt", f_gnt, 0);
      check("rst_l_gnt", l_gnt, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_f_rvalid", f_rvalid, 0);
      check("rst_l_rvalid", l_rvalid, 0);
    end else begin
      fw  = fetch_wins();
      lw  = l_req && !fw;
      sel = lw ? l_addr : f_addr;
      inr = in_range(sel);
      check("f_gnt", f_gnt, 32'(fw));
      check("l_gnt", l_gnt, 32'(lw));
      check("mem_en", mem_en, 32'((fw || lw) && inr));
      check("mem_we", mem_we, 32'(lw && l_we && inr));
      if (fw || lw) check("mem_addr", 32'(mem_addr), 32'(sel[AW+1:2]));
      if (lw && l_we && inr) check("mem_wdata", mem_wdata, l_wdata);
      check("f_rvalid", f_rvalid, 32'(exp_now.f_valid));
      check("l_rvalid", l_rvalid, 32'(exp_now.l_valid));
      check("f_rdata", f_rdata, exp_now.f_valid ? exp_now.data : hold_f);
      check("l_rdata", l_rdata, exp_now.l_valid ? exp_now.data : hold_l);
      if (exp_now.f_valid) check("f_err", f_err, 32'(exp_now.err));
      if (exp_now.l_valid || exp_now.l_drop) check("l_err", l_err, 32'(exp_now.err));
    end
  end

  // ---------------- stimulus ----------------
  // Each call advances one cycle, applies the inputs, and returns at the
  // falling edge so the grant-cycle outputs can be inspected.
  task automatic run(input bit fr, input logic [31:0] fa, input bit lr,
                     input bit lwe, input logic [31:0] la, input logic [31:0] lwd);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; l_req = lr; l_we = lwe; l_addr = la; l_wdata = lwd;
    @(negedge clk);
  endtask

  task automatic idle();
    run(0, 32'd0, 0, 0, 32'd0, 32'd0);
  endtask

  logic [9:0] pat;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_array[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
      model_mem[i] = 32'h1000_0000 + 32'(i) * 32'h0001_0003;
    end
    mem_array[2] = 32'h0062_E233;
    model_mem[2] = 32'h0062_E233;

    rst = 1'b0;
    f_req = 0; f_addr = 0; l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Fetch only, word 2, three back-to-back grants.
    for (int i = 0; i < 3; i++) begin
      run(1, 32'h8, 0, 0, 32'd0, 32'd0);
      check("fo_gnt", f_gnt, 1);
      check("fo_addr", 32'(mem_addr), 2);
      if (i > 0) check("fo_rdata", f_rdata, 32'h0062_E233);
    end
    idle();
    check("fo_last_rvalid", f_rvalid, 1);
    check("fo_last_rdata", f_rdata, 32'h0062_E233);

    // Loader write, then fetch reads the new word.
    run(0, 32'd0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    check("lw_we", mem_we, 1);
    check("lw_addr", 32'(mem_addr), 4);
    run(1, 32'h10, 0, 0, 32'd0, 32'd0);
    check("lw_no_rvalid", l_rvalid, 0);
    idle();
    check("wr_rd_data", f_rdata, 32'hDEAD_BEEF);

    // Contention: fetch is granted every fifth cycle.
    idle();
    pat = '0;
    for (int i = 0; i < 10; i++) begin
      run(1, 32'h8, 1, 0, 32'h20, 32'd0);
      pat = {pat[8:0], f_gnt};
    end
    check("contention_pattern", 32'(pat), 32'b00_0010_0001);
    idle();

    // Out-of-range fetch read and loader write.
    run(1, 32'h1000, 0, 0, 32'd0, 32'd0);
    check("oor_f_en", mem_en, 0);
    idle();
    check("oor_f_rvalid", f_rvalid, 1);
    check("oor_f_rdata", f_rdata, 0);
    check("oor_f_err", f_err, 1);
    run(0, 32'd0, 1, 1, 32'h1000, 32'h5555_AAAA);
    check("oor_l_we", mem_we, 0);
    idle();
    check("oor_l_err", l_err, 1);
    check("oor_l_rvalid", l_rvalid, 0);
    idle();
    check("oor_l_err_pulse", l_err, 0);

    // Misaligned fetch address.
    run(1, 32'hB, 0, 0, 32'd0, 32'd0);
    check("mis_addr", 32'(mem_addr), 2);
    idle();
    check("mis_rdata", f_rdata, 32'h0062_E233);

    // Alternating owners, boundary indices, and an upper-bit alias.
    run(1, 32'h4, 0, 0, 32'd0, 32'd0);
    run(0, 32'd0, 1, 0, 32'h8, 32'd0);
    run(1, 32'hFFC, 0, 0, 32'd0, 32'd0);
    check("edge_addr", 32'(mem_addr), 32'h3FF);
    run(0, 32'd0, 1, 1, 32'hFFC, 32'h1234_5678);
    run(0, 32'd0, 1, 0, 32'hFFC, 32'd0);
    run(1, 32'hFFC, 0, 0, 32'd0, 32'd0);
    check("edge_l_rdata", l_rdata, 32'h1234_5678);
    run(0, 32'd0, 1, 0, 32'h8000_0008, 32'd0);
    check("alias_en", mem_en, 0);
    idle();
    check("alias_l_err", l_err, 1);
    check("alias_l_rdata", l_rdata, 0);

    // Reset in the middle of a fetch read.
    run(1, 32'h8, 0, 0, 32'd0, 32'd0);
    check("rmr_gnt", f_gnt, 1);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("rmr_rvalid", f_rvalid, 0);
    check("rmr_gnt_forced", f_gnt, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    f_req = 1'b0;
    @(negedge clk);
    check("rmr_no_rvalid", f_rvalid, 0);
    run(1, 32'h8, 0, 0, 32'd0, 32'd0);
    idle();
    check("rmr_recover", f_rdata, 32'h0062_E233);
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
